nd_4to1_sched: RTL and testbench

- Round-robin scheduler that shares one outgoing messaging-cell channel (snd0) between four incoming channels (rcv0..rcv3).
- Uses the same 4-phase req/ack channel protocol as the node blocks.
- Sits between node-level producers and a single link or buffer input, replacing ad-hoc two-way alternation with fair N-way scheduling.
- Holds one message in an output register; never buffers more than one message.

---
 rtl/nd_4to1_sched_pkg.sv | 17 +
 rtl/nd_rr_pick.sv | 30 +++
 rtl/nd_4to1_sched.sv | 172 +++++++++++++++++
 tb/tb_nd_4to1_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nd_4to1_sched_pkg.sv
// Shared definitions for the 4-to-1 round-robin channel scheduler:
// default field widths, input count and the scheduler state encoding.
package nd_4to1_sched_pkg;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 4;
    localparam int NS_NUM_IN       = 4;

    typedef enum logic [1:0] {
        NS_SCHED_INIT     = 2'd0,
        NS_SCHED_IDLE     = 2'd1,
        NS_SCHED_WAIT_ACK = 2'd2,
        NS_SCHED_WAIT_REL = 2'd3
    } sched_state_t;

endpackage

// File: rtl/nd_rr_pick.sv
// Combinational round-robin picker: first pending index scanning
// last+1, last+2, ... modulo 4. The last winner is considered last.
module nd_rr_pick
    import nd_4to1_sched_pkg::*;
(
    input  logic [NS_NUM_IN-1:0] pend,
    input  logic [1:0]           last,
    output logic                 any,
    output logic [1:0]           win
);

    logic [1:0] idx;
    logic       found;

    // scan from the slot after the previous winner, wrapping around
    always_comb begin
        any   = |pend;
        win   = last;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= NS_NUM_IN; i++) begin
            idx = last + 2'(i);
            if (!found && pend[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nd_4to1_sched.sv
// Round-robin scheduler sharing one outgoing 4-phase req/ack channel
// (snd0) between four incoming channels (rcv0..rcv3). One message is
// held in the output register at most.
// Optional macro ND_SCHED_CNT_EN adds saturating per-input grant
// counters on the cnt_grants port.
//
// state     | meaning
// ----------+-------------------------------------------------
// INIT      | first cycle after reset, no grant issued
// IDLE      | waiting for a pending input, grants on this edge
// WAIT_ACK  | snd0_req high, waiting for sink acknowledge
// WAIT_REL  | snd0_req low, waiting for sink to drop acknowledge
module nd_4to1_sched
    import nd_4to1_sched_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE,
    parameter int CSZ = 8
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,

    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req,
    input  logic           snd0_ack,

    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv0_req,
    output logic           rcv0_ack,

    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack,

    input  logic [ASZ-1:0] rcv2_src,
    input  logic [ASZ-1:0] rcv2_dst,
    input  logic [DSZ-1:0] rcv2_dat,
    input  logic [RSZ-1:0] rcv2_red,
    input  logic           rcv2_req,
    output logic           rcv2_ack,

    input  logic [ASZ-1:0] rcv3_src,
    input  logic [ASZ-1:0] rcv3_dst,
    input  logic [DSZ-1:0] rcv3_dat,
    input  logic [RSZ-1:0] rcv3_red,
    input  logic           rcv3_req,
    output logic           rcv3_ack
`ifdef ND_SCHED_CNT_EN
    ,
    output logic [4*CSZ-1:0] cnt_grants
`endif
);

    sched_state_t state, state_nxt;

    logic [NS_NUM_IN-1:0] req_v;
    logic [NS_NUM_IN-1:0] ack_r;
    logic [NS_NUM_IN-1:0] pend;
    logic [1:0]           last;
    logic [1:0]           win;
    logic                 any;
    logic                 grant;

    logic [ASZ-1:0] src_v [NS_NUM_IN];
    logic [ASZ-1:0] dst_v [NS_NUM_IN];
    logic [DSZ-1:0] dat_v [NS_NUM_IN];
    logic [RSZ-1:0] red_v [NS_NUM_IN];

    assign req_v = {rcv3_req, rcv2_req, rcv1_req, rcv0_req};
    assign src_v = '{rcv0_src, rcv1_src, rcv2_src, rcv3_src};
    assign dst_v = '{rcv0_dst, rcv1_dst, rcv2_dst, rcv3_dst};
    assign dat_v = '{rcv0_dat, rcv1_dat, rcv2_dat, rcv3_dat};
    assign red_v = '{rcv0_red, rcv1_red, rcv2_red, rcv3_red};

    assign rcv0_ack = ack_r[0];
    assign rcv1_ack = ack_r[1];
    assign rcv2_ack = ack_r[2];
    assign rcv3_ack = ack_r[3];

    // an input still holding its ack is not eligible again
    assign pend = req_v & ~ack_r;

    nd_rr_pick u_pick (
        .pend (pend),
        .last (last),
        .any  (any),
        .win  (win)
    );

    // state register
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) state <= NS_SCHED_INIT;
        else       state <= state_nxt;
    end

    // next-state logic; snd0_ack outside the handshake states is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            NS_SCHED_INIT:     state_nxt = NS_SCHED_IDLE;
            NS_SCHED_IDLE:     if (any)       state_nxt = NS_SCHED_WAIT_ACK;
            NS_SCHED_WAIT_ACK: if (snd0_ack)  state_nxt = NS_SCHED_WAIT_REL;
            NS_SCHED_WAIT_REL: if (!snd0_ack) state_nxt = NS_SCHED_IDLE;
            default:           state_nxt = NS_SCHED_INIT;
        endcase
    end

    // state decode: outgoing request is exactly the WAIT_ACK phase
    always_comb begin
        ready    = (state != NS_SCHED_INIT);
        snd0_req = (state == NS_SCHED_WAIT_ACK);
        grant    = (state == NS_SCHED_IDLE) && any;
    end

    // per-input ack: set on grant, released once the requester drops req
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            ack_r <= '0;
        end else begin
            for (int k = 0; k < NS_NUM_IN; k++) begin
                if (grant && (win == 2'(k))) ack_r[k] <= 1'b1;
                else if (ack_r[k] && !req_v[k]) ack_r[k] <= 1'b0;
            end
        end
    end

    // output message register and round-robin pointer, loaded on grant
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            last     <= 2'd3;
            snd0_src <= '0;
            snd0_dst <= '0;
            snd0_dat <= '0;
            snd0_red <= '0;
        end else if (grant) begin
            last     <= win;
            snd0_src <= src_v[win];
            snd0_dst <= dst_v[win];
            snd0_dat <= dat_v[win];
            snd0_red <= red_v[win];
        end
    end

`ifdef ND_SCHED_CNT_EN
    // saturating grant counters, one CSZ-bit field per input
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            cnt_grants <= '0;
        end else if (grant) begin
            for (int k = 0; k < NS_NUM_IN; k++) begin
                if ((win == 2'(k)) && (cnt_grants[k*CSZ +: CSZ] != {CSZ{1'b1}}))
                    cnt_grants[k*CSZ +: CSZ] <= cnt_grants[k*CSZ +: CSZ] + CSZ'(1);
            end
        end
    end
`else
    logic [31:0] unused_csz;
    assign unused_csz = 32'(CSZ);
`endif

endmodule

// File: tb/tb_nd_4to1_sched.sv
// Directed bench for nd_4to1_sched. Build with ND_SCHED_CNT_EN to also
// exercise the grant counters (instantiated with CSZ=2).
module tb_nd_4to1_sched;

    logic       i_clk;
    logic       reset;
    logic       ready;
    logic [7:0] snd0_src, snd0_dst, snd0_dat;
    logic [3:0] snd0_red;
    logic       snd0_req;
    logic       snd0_ack;

    logic [7:0] src [4];
    logic [7:0] dst [4];
    logic [7:0] dat [4];
    logic [3:0] red [4];
    logic [3:0] req;
    logic       rcv0_ack, rcv1_ack, rcv2_ack, rcv3_ack;
    logic [3:0] ack_v;
`ifdef ND_SCHED_CNT_EN
    logic [7:0] cnt_grants;
`endif

    assign ack_v = {rcv3_ack, rcv2_ack, rcv1_ack, rcv0_ack};

    nd_4to1_sched #(.ASZ(8), .DSZ(8), .RSZ(4), .CSZ(2)) dut (
        .i_clk    (i_clk),
        .reset    (reset),
        .ready    (ready),
        .snd0_src (snd0_src),
        .snd0_dst (snd0_dst),
        .snd0_dat (snd0_dat),
        .snd0_red (snd0_red),
        .snd0_req (snd0_req),
        .snd0_ack (snd0_ack),
        .rcv0_src (src[0]), .rcv0_dst (dst[0]), .rcv0_dat (dat[0]), .rcv0_red (red[0]),
        .rcv0_req (req[0]), .rcv0_ack (rcv0_ack),
        .rcv1_src (src[1]), .rcv1_dst (dst[1]), .rcv1_dat (dat[1]), .rcv1_red (red[1]),
        .rcv1_req (req[1]), .rcv1_ack (rcv1_ack),
        .rcv2_src (src[2]), .rcv2_dst (dst[2]), .rcv2_dat (dat[2]), .rcv2_red (red[2]),
        .rcv2_req (req[2]), .rcv2_ack (rcv2_ack),
        .rcv3_src (src[3]), .rcv3_dst (dst[3]), .rcv3_dat (dat[3]), .rcv3_red (red[3]),
        .rcv3_req (req[3]), .rcv3_ack (rcv3_ack)
`ifdef ND_SCHED_CNT_EN
        ,
        .cnt_grants (cnt_grants)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // behavioural environment state
    int         sink_dly = 1;
    int         sink_cnt = 0;
    logic [3:0] hold     = '0;
    logic [3:0] cont     = '0;
    logic [3:0] prev_ack = '0;
    int         g_idx [$];
    int         g_cyc [$];
    logic [7:0] g_src [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        g_idx.delete();
        g_cyc.delete();
        g_src.delete();
    endtask

    // one clock: sample at negedge, log grants, then run sink and requesters
    task automatic cyc();
        @(negedge i_clk);
        cyc_n++;
        for (int k = 0; k < 4; k++) begin
            if (ack_v[k] && !prev_ack[k]) begin
                g_idx.push_back(k);
                g_cyc.push_back(cyc_n);
                g_src.push_back(snd0_src);
            end
        end
        prev_ack = ack_v;
        if (!snd0_req) begin
            snd0_ack = 1'b0;
            sink_cnt = 0;
        end else if (!snd0_ack) begin
            sink_cnt++;
            if (sink_cnt >= sink_dly + 1) snd0_ack = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            if (ack_v[k]) begin
                if (!hold[k]) req[k] = 1'b0;
            end else if (!req[k] && cont[k]) begin
                req[k] = 1'b1;
            end
        end
    endtask

    initial begin
        int c0;
        reset    = 1'b1;
        snd0_ack = 1'b0;
        req      = '0;
        for (int k = 0; k < 4; k++) begin
            src[k] = 8'h00; dst[k] = 8'h00; dat[k] = 8'h00; red[k] = 4'h0;
        end

        // ---- reset state and INIT cycle
        cyc(); cyc();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_req",   32'(snd0_req), 32'd0);
        chk("rst_acks",  32'(ack_v), 32'd0);
        chk("rst_fields", {snd0_src, snd0_dst, snd0_dat, 4'h0, snd0_red}, 32'd0);
`ifdef ND_SCHED_CNT_EN
        chk("rst_cnt", 32'(cnt_grants), 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("init_ready_before_edge", 32'(ready), 32'd0);
        cyc();
        chk("init_ready_after_edge", 32'(ready), 32'd1);
        cyc(); cyc();
        chk("idle_no_req", 32'(snd0_req), 32'd0);

        // ---- single message from rcv2, sink answers after 2 clocks
        sink_dly = 2;
        src[2] = 8'd5; dst[2] = 8'd9; dat[2] = 8'hA5; red[2] = 4'h3;
        req[2] = 1'b1;
        cyc();
        chk("t2_ack2",  32'(ack_v), 32'b0100);
        chk("t2_req",   32'(snd0_req), 32'd1);
        chk("t2_fields", {snd0_src, snd0_dst, snd0_dat, 4'h0, snd0_red}, 32'h0509A503);
        cyc();
        chk("t2_ack2_released", 32'(ack_v), 32'd0);
        chk("t2_req_hold1", 32'(snd0_req), 32'd1);
        cyc();
        chk("t2_req_hold2", 32'(snd0_req), 32'd1);
        cyc();
        chk("t2_req_fall", 32'(snd0_req), 32'd0);
        chk("t2_fields_wrel", {snd0_src, snd0_dst, snd0_dat, 4'h0, snd0_red}, 32'h0509A503);
        cyc();
        chk("t2_fields_idle", {snd0_src, snd0_dst, snd0_dat, 4'h0, snd0_red}, 32'h0509A503);

        // ---- rcv1 keeps req high after ack; rcv3 must be served next
        sink_dly = 1;
        clr_log();
        src[1] = 8'h11; dst[1] = 8'h12; dat[1] = 8'h13; red[1] = 4'h1;
        src[3] = 8'h33; dst[3] = 8'h34; dat[3] = 8'h35; red[3] = 4'h3;
        hold[1] = 1'b1;
        req[1]  = 1'b1;
        cyc();
        chk("t4_grant1", 32'(ack_v), 32'b0010);
        chk("t4_src1",   32'(snd0_src), 32'h11);
        req[3] = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        chk("t4_grant3", 32'(ack_v), 32'b1010);
        chk("t4_src3",   32'(snd0_src), 32'h33);
        for (int i = 0; i < 8; i++) cyc();
        chk("t4_no_regrant_req", 32'(snd0_req), 32'd0);
        chk("t4_ack1_held",      32'(ack_v), 32'b0010);
        chk("t4_grant_count",    32'(g_idx.size()), 32'd2);
        hold[1] = 1'b0;
        cyc(); cyc();
        chk("t4_ack1_cleared", 32'(ack_v), 32'd0);
        req[1] = 1'b1;
        cyc();
        chk("t4_regrant1", 32'(ack_v), 32'b0010);
        chk("t4_regrant_req", 32'(snd0_req), 32'd1);

        // ---- reset mid-transfer: everything drops without a clock edge
        reset = 1'b1;
        #1;
        chk("t5_req_async",   32'(snd0_req), 32'd0);
        chk("t5_acks_async",  32'(ack_v), 32'd0);
        chk("t5_ready_async", 32'(ready), 32'd0);
        chk("t5_src_async",   32'(snd0_src), 32'd0);
        for (int k = 0; k < 4; k++) begin
            src[k] = 8'h40 + 8'(k); dst[k] = 8'h50 + 8'(k);
            dat[k] = 8'h60 + 8'(k); red[k] = 4'(k);
        end
        hold = '0;
        cont = 4'b1111;
        req  = 4'b1111;
        cyc(); cyc();
        chk("t5_no_grant_in_reset", 32'(ack_v), 32'd0);
        reset = 1'b0;
        clr_log();
        cyc();
        c0 = cyc_n;
        chk("t5_init_ready", 32'(ready), 32'd1);
        chk("t5_init_no_grant", 32'(snd0_req), 32'd0);

        // ---- all four requesting: rotation 0,1,2,3,0,1 every 4 clocks
        for (int i = 0; i < 40 && g_idx.size() < 6; i++) cyc();
        chk("t3_timeout", 32'(g_idx.size() >= 6), 32'd1);
        if (g_idx.size() >= 6) begin
            chk("t3_first_latency", 32'(g_cyc[0] - c0), 32'd1);
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("t3_order%0d", i), 32'(g_idx[i]), 32'(i % 4));
                chk($sformatf("t3_src%0d", i), 32'(g_src[i]), 32'h40 + 32'(i % 4));
                if (i > 0)
                    chk($sformatf("t3_space%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd4);
            end
        end
        cont = '0;
        for (int i = 0; i < 20; i++) cyc();
        chk("t3_drained", 32'(snd0_req), 32'd0);

`ifdef ND_SCHED_CNT_EN
        // ---- counters: five grants to input 0 saturate a 2-bit field
        reset = 1'b1;
        req   = '0;
        #1;
        chk("t6_cnt_reset", 32'(cnt_grants), 32'd0);
        cyc();
        reset = 1'b0;
        clr_log();
        cont[0] = 1'b1;
        req[0]  = 1'b1;
        for (int i = 0; i < 60 && g_idx.size() < 5; i++) cyc();
        chk("t6_timeout", 32'(g_idx.size() >= 5), 32'd1);
        chk("t6_cnt_sat", 32'(cnt_grants), 32'h03);
        cont = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
